// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the KGP-miniRISC datapath: a FETCH/DECODE/EXEC/MEM/WB/BRANCH/HALT
// state machine with ready handshakes, a memory watchdog and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned FUNC_W      = 6,
    parameter int unsigned HALT_OPCODE = 63,
    parameter int unsigned WAIT_LIMIT  = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_enable,
    output logic                ir_write,
    output logic                pc_incr,
    output logic [1:0]          reg_write,
    output logic                imm_mux_ctrl,
    output logic                alu_mux_ctrl,
    output logic [3:0]          alu_op,
    output logic                dmem_enable,
    output logic                dmem_write_enable,
    output logic [1:0]          reg_write_mux_ctrl,
    output logic [4:0]          br_op,
    output logic [2:0]          state,
    output logic                halted,
    output logic                illegal_instr,
    output logic                mem_err,
    output logic [CNT_W-1:0]    instret
);

    localparam int unsigned WaitW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StBranch = 3'd5,
        StHalt   = 3'd7
    } state_e;

    typedef enum logic [1:0] {ClsAlu, ClsLoad, ClsStore, ClsBranch} cls_e;

    typedef struct packed {
        cls_e       cls;
        logic [3:0] alu_op;
        logic       imm_mux;
        logic       alu_mux;
        logic [1:0] reg_write;
        logic [1:0] wb_mux;
        logic [4:0] br_op;
    } dec_t;

    state_e           state_q, state_d;
    dec_t             dec_q, dec_d;
    logic             dec_halt, dec_illegal;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] instret_q;
    logic             mem_err_q, mem_err_d;
    logic             illegal_q, illegal_d;
    logic             retire, timeout, drive_alu;
    logic [31:0]      op_ext, func_ext;

    assign op_ext   = 32'(opcode);
    assign func_ext = 32'(func);

    // Counter holds WAIT_LIMIT-1 during the last permitted stall cycle.
    assign timeout = (WAIT_LIMIT != 0) && (wait_q == WaitW'(WAIT_LIMIT - 1));

    always_comb begin
        dec_d       = '0;
        dec_halt    = 1'b0;
        dec_illegal = 1'b0;
        if (op_ext == HALT_OPCODE) begin
            dec_halt = 1'b1;
        end else begin
            case (op_ext)
                32'd0: begin
                    case (func_ext)
                        32'd0:   dec_d.alu_op = 4'd0;
                        32'd1:   dec_d.alu_op = 4'd1;
                        default: dec_illegal = 1'b1;
                    endcase
                end
                32'd1: begin
                    dec_d.alu_mux = 1'b1;
                    case (func_ext)
                        32'd0:   dec_d.alu_op = 4'd0;
                        32'd1:   dec_d.alu_op = 4'd1;
                        default: dec_illegal = 1'b1;
                    endcase
                end
                32'd10: begin
                    case (func_ext)
                        32'd0:   dec_d.alu_op = 4'd2;
                        32'd1:   dec_d.alu_op = 4'd3;
                        default: dec_illegal = 1'b1;
                    endcase
                end
                32'd20: begin
                    case (func_ext)
                        32'd0:   dec_d.alu_op = 4'd4;
                        32'd1:   dec_d.alu_op = 4'd5;
                        32'd2:   dec_d.alu_op = 4'd6;
                        default: dec_illegal = 1'b1;
                    endcase
                end
                32'd21: begin
                    case (func_ext)
                        32'd0:   dec_d.alu_op = 4'd12;
                        32'd1:   dec_d.alu_op = 4'd13;
                        32'd2:   dec_d.alu_op = 4'd14;
                        default: dec_illegal = 1'b1;
                    endcase
                end
                32'd50: dec_d.alu_op = 4'd7;
                32'd30: begin
                    dec_d.cls       = ClsLoad;
                    dec_d.imm_mux   = 1'b1;
                    dec_d.alu_mux   = 1'b1;
                    dec_d.reg_write = 2'b10;
                    dec_d.wb_mux    = 2'd1;
                end
                32'd31: begin
                    dec_d.cls     = ClsStore;
                    dec_d.imm_mux = 1'b1;
                    dec_d.alu_mux = 1'b1;
                end
                32'd40: begin dec_d.cls = ClsBranch; dec_d.br_op = 5'b00001; end
                32'd41: begin
                    dec_d.cls       = ClsBranch;
                    dec_d.br_op     = 5'b00101;
                    dec_d.reg_write = 2'b11;
                end
                32'd42: begin dec_d.cls = ClsBranch; dec_d.br_op = 5'b00100; end
                32'd43: begin dec_d.cls = ClsBranch; dec_d.br_op = 5'b01100; end
                32'd44: begin dec_d.cls = ClsBranch; dec_d.br_op = 5'b00010; end
                32'd45: begin dec_d.cls = ClsBranch; dec_d.br_op = 5'b00011; end
                32'd46: begin dec_d.cls = ClsBranch; dec_d.br_op = 5'b01011; end
                32'd47: begin dec_d.cls = ClsBranch; dec_d.br_op = 5'b10011; end
                default: dec_illegal = 1'b1;
            endcase
            if (dec_d.cls == ClsAlu) begin
                dec_d.reg_write = 2'b01;
                dec_d.wb_mux    = 2'd2;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        wait_d             = '0;
        mem_err_d          = mem_err_q;
        illegal_d          = illegal_q;
        retire             = 1'b0;
        drive_alu          = 1'b0;
        imem_enable        = 1'b0;
        ir_write           = 1'b0;
        pc_incr            = 1'b0;
        reg_write          = 2'b00;
        imm_mux_ctrl       = 1'b0;
        alu_mux_ctrl       = 1'b0;
        alu_op             = 4'd0;
        dmem_enable        = 1'b0;
        dmem_write_enable  = 1'b0;
        reg_write_mux_ctrl = 2'd0;
        br_op              = 5'd0;
        halted             = 1'b0;

        unique case (state_q)
            StFetch: begin
                imem_enable = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_incr  = 1'b1;
                    state_d  = StDecode;
                end else if (timeout) begin
                    mem_err_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDecode: begin
                if (dec_halt) begin
                    state_d = StHalt;
                end else if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end else if (dec_d.cls == ClsBranch) begin
                    state_d = StBranch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                drive_alu = 1'b1;
                state_d   = (dec_q.cls == ClsAlu) ? StWb : StMem;
            end
            StMem: begin
                drive_alu         = 1'b1;
                dmem_enable       = 1'b1;
                dmem_write_enable = (dec_q.cls == ClsStore);
                if (dmem_ready) begin
                    if (dec_q.cls == ClsStore) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    mem_err_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWb: begin
                drive_alu          = 1'b1;
                reg_write          = dec_q.reg_write;
                reg_write_mux_ctrl = dec_q.wb_mux;
                retire             = 1'b1;
                state_d            = StFetch;
            end
            StBranch: begin
                br_op     = dec_q.br_op;
                reg_write = dec_q.reg_write;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StHalt: halted = 1'b1;
            default: state_d = StFetch;
        endcase

        if (drive_alu) begin
            alu_op       = dec_q.alu_op;
            imm_mux_ctrl = dec_q.imm_mux;
            alu_mux_ctrl = dec_q.alu_mux;
        end

        // The reset state is FETCH, but no request may leave while rst is held.
        if (rst) begin
            imem_enable = 1'b0;
            ir_write    = 1'b0;
            pc_incr     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            dec_q     <= '0;
            instret_q <= '0;
            mem_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
            illegal_q <= illegal_d;
            if (state_q == StDecode) begin
                dec_q <= dec_d;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign state         = state_q;
    assign instret       = instret_q;
    assign mem_err       = mem_err_q;
    assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected outputs are queued with the
// stimulus that produces them and compared as the sequencer steps through each instruction.
module tb_multicycle_control_unit;

    localparam int unsigned WL = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode, func;
    logic          imem_ready, dmem_ready;
    logic          imem_enable, ir_write, pc_incr, imm_mux_ctrl, alu_mux_ctrl;
    logic          dmem_enable, dmem_write_enable, halted, illegal_instr, mem_err;
    logic [1:0]    reg_write, reg_write_mux_ctrl;
    logic [3:0]    alu_op;
    logic [4:0]    br_op;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    multicycle_control_unit #(
        .OPCODE_W   (6),
        .FUNC_W     (6),
        .HALT_OPCODE(63),
        .WAIT_LIMIT (WL),
        .CNT_W      (CW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .opcode            (opcode),
        .func              (func),
        .imem_ready        (imem_ready),
        .dmem_ready        (dmem_ready),
        .imem_enable       (imem_enable),
        .ir_write          (ir_write),
        .pc_incr           (pc_incr),
        .reg_write         (reg_write),
        .imm_mux_ctrl      (imm_mux_ctrl),
        .alu_mux_ctrl      (alu_mux_ctrl),
        .alu_op            (alu_op),
        .dmem_enable       (dmem_enable),
        .dmem_write_enable (dmem_write_enable),
        .reg_write_mux_ctrl(reg_write_mux_ctrl),
        .br_op             (br_op),
        .state             (state),
        .halted            (halted),
        .illegal_instr     (illegal_instr),
        .mem_err           (mem_err),
        .instret           (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    state;
        logic          imem_en;
        logic          ir_write;
        logic          pc_incr;
        logic [1:0]    reg_write;
        logic [1:0]    wb_mux;
        logic [3:0]    alu_op;
        logic          alu_mux;
        logic          imm_mux;
        logic          dmem_en;
        logic          dmem_we;
        logic [4:0]    br_op;
        logic          halted;
        logic          illegal;
        logic          mem_err;
        logic [CW-1:0] instret;
    } obs_t;

    localparam int OBW = $bits(obs_t);

    typedef struct packed {
        logic       ir;
        logic       dr;
        logic [5:0] op;
        logic [5:0] fn;
        obs_t       exp;
    } item_t;

    typedef struct packed {
        logic [2:0] kind;
        logic [3:0] alu_op;
        logic       alu_mux;
        logic       imm_mux;
        logic [1:0] rw;
        logic [1:0] wbm;
        logic [4:0] br;
    } dec_t;

    localparam logic [2:0] KAlu = 3'd0, KLw = 3'd1, KSw = 3'd2, KBr = 3'd3, KHalt = 3'd4,
                           KIll = 3'd5;

    logic [4:0]    bcodes [8] = '{5'b00001, 5'b00101, 5'b00100, 5'b01100,
                                  5'b00010, 5'b00011, 5'b01011, 5'b10011};
    item_t         sbq [$];
    logic [CW-1:0] m_cnt;
    logic          m_ill, m_merr;
    int            nchk = 0;
    int            nfail = 0;

    function automatic dec_t ref_dec(input logic [5:0] op, input logic [5:0] fn);
        dec_t r = '0;
        r.kind = KIll;
        case (op)
            6'd0:  if (fn < 6'd2) begin r.kind = KAlu; r.alu_op = 4'(fn); end
            6'd1:  if (fn < 6'd2) begin r.kind = KAlu; r.alu_op = 4'(fn); r.alu_mux = 1'b1; end
            6'd10: if (fn < 6'd2) begin r.kind = KAlu; r.alu_op = 4'd2 + 4'(fn); end
            6'd20: if (fn < 6'd3) begin r.kind = KAlu; r.alu_op = 4'd4 + 4'(fn); end
            6'd21: if (fn < 6'd3) begin r.kind = KAlu; r.alu_op = 4'd12 + 4'(fn); end
            6'd50: begin r.kind = KAlu; r.alu_op = 4'd7; end
            6'd30: begin
                r.kind = KLw; r.imm_mux = 1'b1; r.alu_mux = 1'b1; r.rw = 2'b10; r.wbm = 2'd1;
            end
            6'd31: begin r.kind = KSw; r.imm_mux = 1'b1; r.alu_mux = 1'b1; end
            6'd63: r.kind = KHalt;
            default: begin
                if (op >= 6'd40 && op <= 6'd47) begin
                    r.kind = KBr;
                    r.br   = bcodes[op - 6'd40];
                    if (op == 6'd41) r.rw = 2'b11;
                end
            end
        endcase
        if (r.kind == KAlu) begin
            r.rw  = 2'b01;
            r.wbm = 2'd2;
        end
        return r;
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t e = '0;
        e.state   = st;
        e.halted  = (st == 3'd7);
        e.illegal = m_ill;
        e.mem_err = m_merr;
        e.instret = m_cnt;
        return e;
    endfunction

    function automatic obs_t with_alu(input obs_t e, input dec_t d);
        obs_t r = e;
        r.alu_op  = d.alu_op;
        r.alu_mux = d.alu_mux;
        r.imm_mux = d.imm_mux;
        return r;
    endfunction

    // ALU/mux controls are only defined from EXEC through WB, the writeback mux only in WB.
    function automatic obs_t care(input logic [2:0] st);
        obs_t m = '1;
        if (!(st inside {3'd2, 3'd3, 3'd4})) begin
            m.alu_op  = '0;
            m.alu_mux = 1'b0;
            m.imm_mux = 1'b0;
        end
        if (st != 3'd4) m.wb_mux = '0;
        return m;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.state = state;          o.imem_en = imem_enable;   o.ir_write = ir_write;
        o.pc_incr = pc_incr;      o.reg_write = reg_write;   o.wb_mux = reg_write_mux_ctrl;
        o.alu_op = alu_op;        o.alu_mux = alu_mux_ctrl;  o.imm_mux = imm_mux_ctrl;
        o.dmem_en = dmem_enable;  o.dmem_we = dmem_write_enable;
        o.br_op = br_op;          o.halted = halted;         o.illegal = illegal_instr;
        o.mem_err = mem_err;      o.instret = instret;
        return o;
    endfunction

    task automatic push(input logic ir, input logic dr, input logic [5:0] op,
                        input logic [5:0] fn, input obs_t e);
        item_t it;
        it.ir = ir; it.dr = dr; it.op = op; it.fn = fn; it.exp = e;
        sbq.push_back(it);
    endtask

    // Waits >= WL model a watchdog expiry in that phase.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                              input int mw);
        dec_t d = ref_dec(op, fn);
        obs_t e;
        for (int i = 0; i < fw && i < int'(WL); i++) begin
            e = base(3'd0); e.imem_en = 1'b1;
            push(1'b0, 1'b1, op, fn, e);
        end
        if (fw >= int'(WL)) begin m_merr = 1'b1; return; end
        e = base(3'd0); e.imem_en = 1'b1; e.ir_write = 1'b1; e.pc_incr = 1'b1;
        push(1'b1, 1'b1, op, fn, e);
        push(1'b1, 1'b1, op, fn, base(3'd1));
        if (d.kind == KHalt) return;
        if (d.kind == KIll) begin m_ill = 1'b1; return; end
        if (d.kind == KBr) begin
            e = base(3'd5); e.br_op = d.br; e.reg_write = d.rw;
            push(1'b1, 1'b1, op, fn, e);
            m_cnt = m_cnt + CW'(1);
            return;
        end
        push(1'b1, 1'b1, op, fn, with_alu(base(3'd2), d));
        if (d.kind != KAlu) begin
            e = with_alu(base(3'd3), d); e.dmem_en = 1'b1; e.dmem_we = (d.kind == KSw);
            for (int i = 0; i < mw && i < int'(WL); i++) push(1'b1, 1'b0, op, fn, e);
            if (mw >= int'(WL)) begin m_merr = 1'b1; return; end
            push(1'b1, 1'b1, op, fn, e);
            if (d.kind == KSw) begin m_cnt = m_cnt + CW'(1); return; end
        end
        e = with_alu(base(3'd4), d); e.reg_write = d.rw; e.wb_mux = d.wbm;
        push(1'b1, 1'b1, op, fn, e);
        m_cnt = m_cnt + CW'(1);
    endtask

    task automatic push_halt(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b1, 6'd0, 6'd0, base(3'd7));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = '0; m_ill = 1'b0; m_merr = 1'b0;
        sbq.delete();
    endtask

    task automatic test_reset();
        item_t it;
        logic [OBW-1:0] ob, mk, ex;
        rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = 6'd0; func = 6'd0;
        m_cnt = '0; m_ill = 1'b0; m_merr = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            ob = observe();
            nchk++;
            if (ob !== '0) begin
                nfail++;
                $display("FAIL reset_outputs: got %h, expected 0", ob);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        push_instr(6'd0, 6'd0, 0, 0);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            imem_ready = it.ir; dmem_ready = it.dr; opcode = it.op; func = it.fn;
            #1;
            ob = observe(); mk = care(it.exp.state); ex = it.exp;
            nchk++;
            if ((ob & mk) !== (ex & mk)) begin
                nfail++;
                $display("FAIL reset_first_add: got %h, expected %h", ob & mk, ex & mk);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu();
        item_t it;
        logic [OBW-1:0] ob, mk, ex;
        logic [5:0] ops [9] = '{6'd0, 6'd0, 6'd1, 6'd1, 6'd10, 6'd10, 6'd20, 6'd21, 6'd50};
        logic [5:0] fns [9] = '{6'd0, 6'd1, 6'd0, 6'd1, 6'd0, 6'd1, 6'd2, 6'd1, 6'd9};
        do_reset();
        for (int i = 0; i < 9; i++) push_instr(ops[i], fns[i], int'($urandom_range(0, 3)), 0);
        push_instr(6'd21, 6'd2, 0, 0);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            imem_ready = it.ir; dmem_ready = it.dr; opcode = it.op; func = it.fn;
            #1;
            ob = observe(); mk = care(it.exp.state); ex = it.exp;
            nchk++;
            if ((ob & mk) !== (ex & mk)) begin
                nfail++;
                $display("FAIL alu op %0d: got %h, expected %h", it.op, ob & mk, ex & mk);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem();
        item_t it;
        logic [OBW-1:0] ob, mk, ex;
        do_reset();
        push_instr(6'd30, 6'd0, 0, 3);
        push_instr(6'd31, 6'd0, 0, 0);
        push_instr(6'd31, 6'd7, 2, 5);
        push_instr(6'd30, 6'd0, 1, 0);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            imem_ready = it.ir; dmem_ready = it.dr; opcode = it.op; func = it.fn;
            #1;
            ob = observe(); mk = care(it.exp.state); ex = it.exp;
            nchk++;
            if ((ob & mk) !== (ex & mk)) begin
                nfail++;
                $display("FAIL mem op %0d: got %h, expected %h", it.op, ob & mk, ex & mk);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        item_t it;
        logic [OBW-1:0] ob, mk, ex;
        do_reset();
        push_instr(6'd41, 6'd0, 0, 0);
        push_instr(6'd47, 6'd0, 0, 0);
        for (int i = 40; i < 48; i++) push_instr(6'(i), 6'(i), int'($urandom_range(0, 2)), 0);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            imem_ready = it.ir; dmem_ready = it.dr; opcode = it.op; func = it.fn;
            #1;
            ob = observe(); mk = care(it.exp.state); ex = it.exp;
            nchk++;
            if ((ob & mk) !== (ex & mk)) begin
                nfail++;
                $display("FAIL branch op %0d: got %h, expected %h", it.op, ob & mk, ex & mk);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_halt();
        item_t it;
        logic [OBW-1:0] ob, mk, ex;
        logic [5:0] bad_op [3] = '{6'd0, 6'd2, 6'd63};
        logic [5:0] bad_fn [3] = '{6'd5, 6'd0, 6'd0};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            push_instr(6'd0, 6'd0, 0, 0);
            push_instr(bad_op[k], bad_fn[k], 0, 0);
            push_halt(5);
            while (sbq.size() > 0) begin
                it = sbq.pop_front();
                imem_ready = it.ir; dmem_ready = it.dr; opcode = it.op; func = it.fn;
                #1;
                ob = observe(); mk = care(it.exp.state); ex = it.exp;
                nchk++;
                if ((ob & mk) !== (ex & mk)) begin
                    nfail++;
                    $display("FAIL halt/illegal case %0d: got %h, expected %h", k, ob & mk,
                             ex & mk);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_watchdog();
        item_t it;
        logic [OBW-1:0] ob, mk, ex;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            if (k == 0) begin
                push_instr(6'd0, 6'd0, int'(WL), 0);
                push_halt(4);
            end else if (k == 1) begin
                push_instr(6'd0, 6'd0, int'(WL) - 1, 0);
            end else begin
                push_instr(6'd30, 6'd0, 0, int'(WL));
                push_halt(3);
            end
            while (sbq.size() > 0) begin
                it = sbq.pop_front();
                imem_ready = it.ir; dmem_ready = it.dr; opcode = it.op; func = it.fn;
                #1;
                ob = observe(); mk = care(it.exp.state); ex = it.exp;
                nchk++;
                if ((ob & mk) !== (ex & mk)) begin
                    nfail++;
                    $display("FAIL watchdog case %0d: got %h, expected %h", k, ob & mk,
                             ex & mk);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        item_t it;
        logic [OBW-1:0] ob, mk, ex;
        do_reset();
        push_instr(6'd31, 6'd0, 0, 30);
        repeat (5) begin
            it = sbq.pop_front();
            imem_ready = it.ir; dmem_ready = it.dr; opcode = it.op; func = it.fn;
            #1;
            ob = observe(); mk = care(it.exp.state); ex = it.exp;
            nchk++;
            if ((ob & mk) !== (ex & mk)) begin
                nfail++;
                $display("FAIL sw_before_reset: got %h, expected %h", ob & mk, ex & mk);
            end
            @(negedge clk);
        end
        sbq.delete();
        imem_ready = 1'b1; dmem_ready = 1'b0;
        #2;
        nchk++;
        if (dmem_enable !== 1'b1 || state !== 3'd3) begin
            nfail++;
            $display("FAIL sw_in_mem: got state %0d dmem_enable %b, expected 3 and 1", state,
                     dmem_enable);
        end
        rst = 1'b1;
        #1;
        ob = observe();
        nchk++;
        if (ob !== '0) begin
            nfail++;
            $display("FAIL async_reset_mid_mem: got %h, expected 0", ob);
        end
        @(negedge clk);
        rst = 1'b0;
        m_cnt = '0; m_ill = 1'b0; m_merr = 1'b0;
        push_instr(6'd10, 6'd1, 0, 0);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            imem_ready = it.ir; dmem_ready = it.dr; opcode = it.op; func = it.fn;
            #1;
            ob = observe(); mk = care(it.exp.state); ex = it.exp;
            nchk++;
            if ((ob & mk) !== (ex & mk)) begin
                nfail++;
                $display("FAIL after_mid_reset: got %h, expected %h", ob & mk, ex & mk);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        item_t it;
        logic [OBW-1:0] ob, mk, ex;
        do_reset();
        for (int i = 0; i < 17; i++) push_instr(6'd40, 6'd0, 0, 0);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            imem_ready = it.ir; dmem_ready = it.dr; opcode = it.op; func = it.fn;
            #1;
            ob = observe(); mk = care(it.exp.state); ex = it.exp;
            nchk++;
            if ((ob & mk) !== (ex & mk)) begin
                nfail++;
                $display("FAIL wrap_seq: got %h, expected %h", ob & mk, ex & mk);
            end
            @(negedge clk);
        end
        imem_ready = 1'b0;
        #1;
        nchk++;
        if (instret !== 4'd1) begin
            nfail++;
            $display("FAIL instret_wrap: got %0d, expected 1", instret);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_illegal_halt();
        test_watchdog();
        test_reset_mid_mem();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: simulation still running at %0t, expected finish", $time);
        $fatal(1, "time limit");
    end

endmodule
